// File: rtl/fc_pkg.sv
// Shared FSM encoding and width helper for the fully-connected layer.
// No logic; imported by fc_param_layer and fc_mac_unit.
package fc_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LOAD,
      ST_MAC,
      ST_DRAIN,
      ST_WRITE
   } fc_state_e;

   function automatic int fc_clog2(input int value);
      int w;
      w = 0;
      while ((1 << w) < value) w++;
      return w;
   endfunction

endpackage

// File: rtl/fc_mac_unit.sv
// Neuron datapath: signed products and Q-aligned bias into a wide accumulator, then rescale, saturate, ReLU.
// Latency: o_result is combinational on the accumulator including the word presented this cycle.
// Backpressure: none; accumulates on every cycle i_acc_en is high.
module fc_mac_unit
   import fc_pkg::*;
#(
   parameter int DATA_W  = 16,
   parameter int FRAC    = 8,
   parameter int ACC_W   = 36,
   parameter int RELU_EN = 1
) (
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic                     i_clr,
   input  logic                     i_acc_en,
   input  logic                     i_is_bias,
   input  logic signed [DATA_W-1:0] i_act,
   input  logic signed [DATA_W-1:0] i_w,
   output logic signed [DATA_W-1:0] o_result
);

   localparam int PW = 2 * DATA_W;
   localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
   localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

   logic signed [PW-1:0]     w_prod;
   logic signed [ACC_W-1:0]  r_acc;
   logic signed [ACC_W-1:0]  w_term;
   logic signed [ACC_W-1:0]  w_acc_next;
   logic signed [ACC_W-1:0]  w_scaled;
   logic signed [DATA_W-1:0] w_sat;

   always_comb begin
      w_prod     = PW'(i_act) * PW'(i_w);
      // bias is a plain Q value; shift it up to the product's 2*FRAC scale
      w_term     = i_is_bias ? (ACC_W'(i_w) <<< FRAC) : ACC_W'(w_prod);
      w_acc_next = i_acc_en ? (r_acc + w_term) : r_acc;
      w_scaled   = w_acc_next >>> FRAC;
      w_sat      = w_scaled[DATA_W-1:0];
      if (w_scaled > SAT_MAX) begin
         w_sat = SAT_MAX[DATA_W-1:0];
      end else if (w_scaled < SAT_MIN) begin
         w_sat = SAT_MIN[DATA_W-1:0];
      end
      o_result = ((RELU_EN != 0) && w_sat[DATA_W-1]) ? '0 : w_sat;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_acc <= '0;
      end else if (i_clr) begin
         r_acc <= '0;
      end else begin
         r_acc <= w_acc_next;
      end
   end

endmodule

// File: rtl/fc_param_layer.sv
// Fully-connected layer: buffers N_IN activations, then one pass over weight memory per output neuron.
// Latency: N_IN accept cycles, then N_IN+3 cycles per neuron (MAC, DRAIN, WRITE).
// Backpressure: in_ready only in LOAD; results are single-cycle we strobes with no output backpressure.
module fc_param_layer
   import fc_pkg::*;
#(
   parameter int DATA_W  = 16,
   parameter int FRAC    = 8,
   parameter int N_IN    = 14,
   parameter int N_OUT   = 10,
   parameter int ACC_W   = 2 * DATA_W + fc_clog2(N_IN + 1),
   parameter int RELU_EN = 1,
   parameter int WADDR_W = 16
) (
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic                     enable,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic signed [DATA_W-1:0] input_value,
   output logic [WADDR_W-1:0]       w_addr,
   input  logic signed [DATA_W-1:0] w_data,
   output logic                     we,
   output logic signed [DATA_W-1:0] out,
   output logic [15:0]              addr,
   output logic                     com_end,
   output logic                     layer_end
);

   localparam int IW = fc_clog2(N_IN + 1);
   localparam int JW = (N_OUT > 1) ? fc_clog2(N_OUT) : 1;

   fc_state_e                r_state;
   fc_state_e                w_next_state;
   logic [IW-1:0]            r_k;
   logic [IW-1:0]            r_i;
   logic [IW-1:0]            r_rd_idx;
   logic [IW-1:0]            w_buf_idx;
   logic [JW-1:0]            r_j;
   logic [WADDR_W-1:0]       r_base;
   logic                     r_rd_vld;
   logic signed [DATA_W-1:0] r_out;
   logic signed [DATA_W-1:0] w_result;
   logic signed [DATA_W-1:0] r_buf [N_IN];
   logic                     w_accept;
   logic                     w_last_in;
   logic                     w_last_j;
   logic                     w_mac_entry;
   logic                     w_is_bias;

   assign w_accept    = (r_state == ST_LOAD) && in_valid;
   assign w_last_in   = w_accept && (r_k == IW'(N_IN - 1));
   assign w_last_j    = (r_j == JW'(N_OUT - 1));
   assign w_mac_entry = (w_next_state == ST_MAC) && (r_state != ST_MAC);
   // weight memory answers one cycle late, so the returned word is tagged with last cycle's index
   assign w_is_bias   = (r_rd_idx == IW'(N_IN));
   assign w_buf_idx   = w_is_bias ? '0 : r_rd_idx;
   assign out         = r_out;

   always_comb begin
      w_next_state = r_state;
      in_ready     = 1'b0;
      we           = 1'b0;
      com_end      = 1'b0;
      layer_end    = 1'b0;
      w_addr       = '0;
      addr         = '0;
      case (r_state)
         ST_IDLE: begin
            if (enable) w_next_state = ST_LOAD;
         end
         ST_LOAD: begin
            in_ready = 1'b1;
            if (w_last_in) w_next_state = ST_MAC;
         end
         ST_MAC: begin
            w_addr = r_base + WADDR_W'(r_i);
            if (r_i == IW'(N_IN)) w_next_state = ST_DRAIN;
         end
         ST_DRAIN: begin
            w_next_state = ST_WRITE;
         end
         ST_WRITE: begin
            we      = 1'b1;
            com_end = 1'b1;
            addr    = 16'(r_j);
            if (w_last_j) begin
               layer_end    = 1'b1;
               w_next_state = ST_IDLE;
            end else begin
               w_next_state = ST_MAC;
            end
         end
         default: w_next_state = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state  <= ST_IDLE;
         r_k      <= '0;
         r_i      <= '0;
         r_j      <= '0;
         r_base   <= '0;
         r_rd_vld <= 1'b0;
         r_rd_idx <= '0;
         r_out    <= '0;
      end else begin
         r_state  <= w_next_state;
         r_rd_vld <= (r_state == ST_MAC);
         r_rd_idx <= r_i;
         if ((r_state == ST_IDLE) && enable) begin
            r_k    <= '0;
            r_j    <= '0;
            r_base <= '0;
         end
         if (w_accept) r_k <= r_k + 1'b1;
         if (w_mac_entry) begin
            r_i <= '0;
         end else if ((r_state == ST_MAC) && (r_i != IW'(N_IN))) begin
            r_i <= r_i + 1'b1;
         end
         if (r_state == ST_DRAIN) r_out <= w_result;
         if ((r_state == ST_WRITE) && !w_last_j) begin
            r_j    <= r_j + 1'b1;
            r_base <= r_base + WADDR_W'(N_IN + 1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (w_accept) r_buf[r_k] <= input_value;
   end

   fc_mac_unit #(
      .DATA_W  (DATA_W),
      .FRAC    (FRAC),
      .ACC_W   (ACC_W),
      .RELU_EN (RELU_EN)
   ) u_mac (
      .clk       (clk),
      .reset_n   (reset_n),
      .i_clr     (w_mac_entry),
      .i_acc_en  (r_rd_vld),
      .i_is_bias (w_is_bias),
      .i_act     (r_buf[w_buf_idx]),
      .i_w       (w_data),
      .o_result  (w_result)
   );

endmodule
